// File: rtl/m_data_mem_pkg.sv
// Shared definitions for the M-stage data memory: access-type encodings and array size default.
package m_data_mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } mem_op_e;

  localparam int DM_WORDS  = 3072;
  localparam int NUM_LANES = 4;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_SW, MEM_SH, MEM_SB};
  endfunction

endpackage

// File: rtl/m_data_mem_load_ext.sv
// Load lane select plus sign/zero extension; shared with any future MMIO read path.
module m_load_ext
  import m_data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [3:0]  op,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  assign half = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    byte_v = word[7:0];
    case (lane)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
  end

  always_comb begin
    data = '0;
    case (op)
      MEM_LW:  data = word;
      MEM_LH:  data = {{16{half[15]}}, half};
      MEM_LHU: data = {16'h0, half};
      MEM_LB:  data = {{24{byte_v[7]}}, byte_v};
      MEM_LBU: data = {24'h0, byte_v};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/m_data_mem.sv
// M-stage data memory: word array, range/alignment check, byte-lane store merge.
// Define DM_TRACE_EN to print one trace line per committed store.
module m_data_mem
  import m_data_mem_pkg::*;
#(
  parameter int WORDS = DM_WORDS,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [3:0]  M_mem_op,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_write_data,
  output logic [31:0] M_read_data,
  output logic        M_addr_exc
);

  localparam logic [31:0] LIMIT = 32'(WORDS * 4);

  logic [31:0]          mem [WORDS];
  logic [AW-1:0]        idx;
  logic [1:0]           lane;
  logic                 ld, st, oor, mis, we;
  logic [31:0]          word, ext, wd_rep, merged;
  logic [NUM_LANES-1:0] be;

  assign idx  = M_addr[AW+1:2];
  assign lane = M_addr[1:0];
  assign ld   = is_load(M_mem_op);
  assign st   = is_store(M_mem_op);
  assign oor  = M_addr >= LIMIT;

  always_comb begin
    mis = 1'b0;
    case (M_mem_op)
      MEM_LW, MEM_SW:          mis = lane != 2'b00;
      MEM_LH, MEM_LHU, MEM_SH: mis = lane[0];
      default:                 mis = 1'b0;
    endcase
  end

  assign M_addr_exc = (ld | st) & (mis | oor);

  // Out-of-range index may exceed the array; never look it up.
  assign word = oor ? '0 : mem[idx];

  m_load_ext u_ext (
    .word (word),
    .lane (lane),
    .op   (M_mem_op),
    .data (ext)
  );

  assign M_read_data = (ld && !M_addr_exc) ? ext : '0;

  always_comb begin
    be     = '0;
    wd_rep = M_write_data;
    case (M_mem_op)
      MEM_SW: be = 4'b1111;
      MEM_SH: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{M_write_data[15:0]}};
      end
      MEM_SB: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{M_write_data[7:0]}};
      end
      default: be = '0;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign merged[8*g +: 8] = be[g] ? wd_rep[8*g +: 8] : word[8*g +: 8];
  end

  assign we = st & ~M_addr_exc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && we)
      $display("%0t@%08h: *%08h <= %08h", $time, M_PC, {M_addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^M_PC;
`endif

endmodule

// File: tb/tb_m_data_mem.sv
// Table-driven bench for m_data_mem with a scoreboard queue of expected outputs.
module tb_m_data_mem;
  import m_data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC, M_addr, M_write_data, M_read_data;
  logic [3:0]  M_mem_op;
  logic        M_addr_exc;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        exc;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        exc;
    string       name;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  m_data_mem dut (
    .clk          (clk),
    .reset        (reset),
    .M_PC         (M_PC),
    .M_mem_op     (M_mem_op),
    .M_addr       (M_addr),
    .M_write_data (M_write_data),
    .M_read_data  (M_read_data),
    .M_addr_exc   (M_addr_exc)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    M_mem_op     = op;
    M_addr       = a;
    M_write_data = wd;
  endtask

  task automatic expect_out(input logic [31:0] rd, input logic exc, input string name);
    exp_t e;
    e.rd   = rd;
    e.exc  = exc;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, nothing to compare");
      return;
    end
    e = sbq.pop_front();
    n_checks++;
    if (M_read_data !== e.rd) begin
      n_fail++;
      $display("FAIL %s read_data: got %08h expected %08h", e.name, M_read_data, e.rd);
    end
    n_checks++;
    if (M_addr_exc !== e.exc) begin
      n_fail++;
      $display("FAIL %s addr_exc: got %0b expected %0b", e.name, M_addr_exc, e.exc);
    end
  endtask

  // One op per cycle: drive just after the edge, compare at the falling edge.
  task automatic apply(input vec_t v, input string name);
    @(posedge clk); #1;
    set_in(v.op, v.addr, v.wdata);
    expect_out(v.rd, v.exc, name);
    @(negedge clk);
    check_out();
  endtask

  task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic exc);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.rd = rd; v.exc = exc;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    M_PC  = 32'h0000_3000;
    set_in(MEM_NONE, 32'h0, 32'h0);

    add(MEM_LW,   32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0);
    add(MEM_SW,   32'h0000_0010, 32'h8899_AABB,  32'h0000_0000, 1'b0);
    add(MEM_LB,   32'h0000_0010, 32'h0,          32'hFFFF_FFBB, 1'b0);
    add(MEM_LBU,  32'h0000_0013, 32'h0,          32'h0000_0088, 1'b0);
    add(MEM_LH,   32'h0000_0012, 32'h0,          32'hFFFF_8899, 1'b0);
    add(MEM_LHU,  32'h0000_0010, 32'h0,          32'h0000_AABB, 1'b0);
    add(MEM_SB,   32'h0000_0011, 32'hFFFF_FF11,  32'h0000_0000, 1'b0);
    add(MEM_LW,   32'h0000_0010, 32'h0,          32'h8899_11BB, 1'b0);
    add(MEM_SH,   32'h0000_0012, 32'hABCD_2233,  32'h0000_0000, 1'b0);
    add(MEM_LW,   32'h0000_0010, 32'h0,          32'h2233_11BB, 1'b0);
    add(MEM_LH,   32'h0000_0012, 32'h0,          32'h0000_2233, 1'b0);
    add(MEM_LB,   32'h0000_0011, 32'h0,          32'h0000_0011, 1'b0);
    add(MEM_SW,   32'h0000_0014, 32'hCAFE_F00D,  32'h0000_0000, 1'b0);
    add(MEM_SW,   32'h0000_0016, 32'hDEAD_BEEF,  32'h0000_0000, 1'b1);
    add(MEM_LW,   32'h0000_0014, 32'h0,          32'hCAFE_F00D, 1'b0);
    add(MEM_SH,   32'h0000_0013, 32'h0000_5555,  32'h0000_0000, 1'b1);
    add(MEM_LW,   32'h0000_0010, 32'h0,          32'h2233_11BB, 1'b0);
    add(MEM_LH,   32'h0000_0011, 32'h0,          32'h0000_0000, 1'b1);
    add(MEM_SW,   32'h0000_2FFC, 32'h5A5A_1234,  32'h0000_0000, 1'b0);
    add(MEM_LW,   32'h0000_2FFC, 32'h0,          32'h5A5A_1234, 1'b0);
    add(MEM_SB,   32'h0000_2FFF, 32'h0000_0077,  32'h0000_0000, 1'b0);
    add(MEM_LW,   32'h0000_2FFC, 32'h0,          32'h775A_1234, 1'b0);
    add(MEM_LW,   32'h0000_3000, 32'h0,          32'h0000_0000, 1'b1);
    add(MEM_SB,   32'h0000_3000, 32'h0000_0099,  32'h0000_0000, 1'b1);
    add(MEM_LW,   32'h8000_0010, 32'h0,          32'h0000_0000, 1'b1);
    add(MEM_SW,   32'h4000_0010, 32'h1111_1111,  32'h0000_0000, 1'b1);
    add(MEM_LW,   32'h0000_0010, 32'h0,          32'h2233_11BB, 1'b0);
    add(MEM_NONE, 32'h0000_3001, 32'h0,          32'h0000_0000, 1'b0);
    add(4'd9,     32'h0000_0010, 32'h0,          32'h0000_0000, 1'b0);
    add(4'd15,    32'h0000_3003, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0);
    add(MEM_LW,   32'h0000_0010, 32'h0,          32'h2233_11BB, 1'b0);

    #12 reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted mid-cycle with a store pending: array clears at once, store never lands.
    @(posedge clk); #1;
    set_in(MEM_SW, 32'h0000_0020, 32'h0000_1234);
    #1 reset = 1'b0;
    #1 set_in(MEM_LW, 32'h0000_0010, 32'h0);
    expect_out(32'h0, 1'b0, "in_reset_lw10");
    #1 check_out();
    set_in(MEM_SW, 32'h0000_0020, 32'h0000_1234);
    expect_out(32'h0, 1'b0, "in_reset_sw20");
    #1 check_out();
    set_in(MEM_SW, 32'h0000_0026, 32'h0000_1234);
    expect_out(32'h0, 1'b1, "in_reset_exc");
    #1 check_out();
    set_in(MEM_SW, 32'h0000_0020, 32'h0000_1234);
    @(posedge clk); #1;
    reset = 1'b1;
    set_in(MEM_NONE, 32'h0, 32'h0);

    v.op = MEM_LW; v.addr = 32'h20; v.wdata = 0; v.rd = 32'h0; v.exc = 1'b0;
    apply(v, "post_reset_lw20");
    v.addr = 32'h10;
    apply(v, "post_reset_lw10");
    v.addr = 32'h2FFC;
    apply(v, "post_reset_lw2ffc");

    // Trace-style store followed by the neighbouring lanes staying zero.
    M_PC = 32'h0000_3008;
    v.op = MEM_SB; v.addr = 32'h21; v.wdata = 32'h0000_007F; v.rd = 0; v.exc = 0;
    apply(v, "sb21");
    M_PC = 32'h0000_300C;
    v.op = MEM_LW; v.addr = 32'h20; v.wdata = 0; v.rd = 32'h0000_7F00;
    apply(v, "lw20_after_sb");
    v.op = MEM_LB; v.addr = 32'h21; v.rd = 32'h0000_007F;
    apply(v, "lb21");

    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d expected entries left unchecked", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
